// File: rtl/fifo_port_arbiter_pkg.sv
// rtl/fifo_port_arbiter_pkg.sv - shared types and constants for the FIFO port arbiter
// Purpose: controller state encoding, skid depth and the occupancy helper.
// Ports: none (package).
package fifo_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    localparam int SKID_DEPTH = 2;

    // Words already committed to the output side: held in the skid plus the
    // one read whose data returns next cycle. Never exceeds SKID_DEPTH.
    function automatic logic [1:0] skid_occupancy(input logic [1:0] cnt, input logic in_flight);
        return cnt + {1'b0, in_flight};
    endfunction

endpackage

// File: rtl/fifo_port_arbiter_skid.sv
// rtl/fifo_port_arbiter_skid.sv - two-entry output skid buffer
// Purpose: holds words returned by the FIFO read port until the consumer takes them.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   capture_i       write data_i at the tail this edge
//   pop_i           drop the head this edge
//   clear_i         empty the buffer (wins over capture and pop)
//   data_i          word to capture
//   count_o         number of held words (0..2)
//   head_o          oldest held word
module fifo_port_arbiter_skid
    import fifo_port_arbiter_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             capture_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [DATAW-1:0] data_i,
    output logic [1:0]       count_o,
    output logic [DATAW-1:0] head_o
);

    logic [DATAW-1:0] head_q, head_d;
    logic [DATAW-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({capture_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) head_d = data_i;
                    else               tail_d = data_i;
                    if (cnt_q != 2'(SKID_DEPTH)) cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous capture and pop: count holds, order is kept.
                    if (cnt_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = data_i;
                    end else begin
                        head_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(capture_i && !pop_i && !clear_i && cnt_q == 2'd2));

    assign count_o = cnt_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fifo_port_arbiter.sv
// rtl/fifo_port_arbiter.sv - round-robin write arbiter and read sequencer for one shared FIFO
// Purpose: two requesters share the FIFO write port; the registered read is turned into a
//          valid/ready output through a skid buffer; a flush request becomes the clean pulse.
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   reqN_valid_i/reqN_data_i/reqN_ready_o requester N handshake (N = 0, 1)
//   out_valid_o/out_data_o/out_ready_i    consumer handshake
//   flush_req_i                           discard all queued data
//   fifo_wable_o/fifo_din_o               FIFO write port
//   fifo_rable_o/fifo_dout_i              FIFO read port (data one cycle after enable)
//   fifo_clean_o                          FIFO pointer clear
//   fifo_full_i/fifo_empty_i              FIFO status
module fifo_port_arbiter
    import fifo_port_arbiter_pkg::*;
#(
    parameter int DATAW     = 32,
    parameter int SKIDDEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_valid_i,
    input  logic [DATAW-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [DATAW-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             out_valid_o,
    output logic [DATAW-1:0] out_data_o,
    input  logic             out_ready_i,
    input  logic             flush_req_i,
    output logic             fifo_wable_o,
    output logic [DATAW-1:0] fifo_din_o,
    output logic             fifo_rable_o,
    input  logic [DATAW-1:0] fifo_dout_i,
    output logic             fifo_clean_o,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i
);

    if (SKIDDEPTH != SKID_DEPTH) begin : g_bad_skiddepth
        $error("fifo_port_arbiter: SKIDDEPTH must be 2");
    end

    state_e           state_q;
    logic             rr_q;          // favoured requester
    logic             in_flight_q;   // a FIFO read returns data this cycle
    logic [1:0]       skid_cnt;
    logic [DATAW-1:0] skid_head;
    logic [1:0]       occ;
    logic             blocked, grant0, grant1, wr_en, pop, out_valid;

    // Reset is folded into the combinational outputs so they drop as soon as
    // rst_ni falls rather than at the next edge.
    assign blocked = !rst_ni || flush_req_i || (state_q == ST_FLUSH);

    assign grant0 = req0_valid_i && (!rr_q || !req1_valid_i);
    assign grant1 = req1_valid_i && (rr_q || !req0_valid_i);

    assign req0_ready_o = grant0 && !fifo_full_i && !blocked;
    assign req1_ready_o = grant1 && !fifo_full_i && !blocked;
    assign wr_en        = req0_ready_o || req1_ready_o;
    assign fifo_wable_o = wr_en;
    assign fifo_din_o   = !rst_ni ? '0 : (grant1 ? req1_data_i : req0_data_i);

    assign out_valid   = (skid_cnt != 2'd0) && !blocked;
    assign out_valid_o = out_valid;
    assign out_data_o  = skid_head;
    assign pop         = out_valid && out_ready_i;

    // Read only when the returning word is guaranteed a skid slot; a pop in
    // the same cycle frees one, which keeps back-to-back throughput.
    assign occ          = skid_occupancy(skid_cnt, in_flight_q);
    assign fifo_rable_o = !fifo_empty_i && !blocked &&
                          ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign fifo_clean_o = flush_req_i && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            in_flight_q <= 1'b0;
        end else begin
            if (wr_en) rr_q <= grant0;
            in_flight_q <= fifo_rable_o;
            if (flush_req_i) begin
                state_q <= ST_FLUSH;
            end else begin
                case (state_q)
                    ST_IDLE:   if (wr_en) state_q <= ST_ACTIVE;
                    ST_ACTIVE: if (fifo_empty_i && skid_cnt == 2'd0 && !in_flight_q && !wr_en)
                                   state_q <= ST_IDLE;
                    ST_FLUSH:  state_q <= ST_IDLE;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // A flush clears the skid at its edge, discarding any word returning then.
    fifo_port_arbiter_skid #(.DATAW(DATAW)) u_skid (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .capture_i (in_flight_q),
        .pop_i     (pop),
        .clear_i   (flush_req_i),
        .data_i    (fifo_dout_i),
        .count_o   (skid_cnt),
        .head_o    (skid_head)
    );

endmodule
